// File: rtl/ins_encoder_pkg.sv
// ins_encoder_pkg: mnemonic enum, instruction format classes and opcode/funct lookup
//   mnem_e  : command mnemonics accepted by ins_encoder (values 39..63 are unknown)
//   kind_e  : field layout class of a mnemonic
//   fmt_of  : mnemonic -> {layout class, opcode or funct}
package ins_encoder_pkg;
  typedef enum logic [5:0] {
    MN_ADD, MN_ADDU, MN_SUB, MN_SUBU, MN_AND, MN_OR, MN_XOR, MN_NOR, MN_SLT, MN_SLTU,
    MN_MULT, MN_MULTU, MN_DIV, MN_DIVU, MN_MFLO, MN_JR,
    MN_ADDI, MN_ADDIU, MN_SLTI, MN_SLTIU, MN_BLT, MN_BEQ, MN_BNE, MN_BLE,
    MN_LW, MN_LB, MN_LBU, MN_LH, MN_LHU, MN_SW, MN_SB, MN_SH,
    MN_ANDI, MN_ORI, MN_XORI, MN_J, MN_JAL, MN_PUSH, MN_POP
  } mnem_e;
  typedef enum logic [3:0] {K_BAD, K_R3, K_R2, K_RD, K_RS, K_IS, K_IU, K_J, K_PUSH, K_POP} kind_e;
  typedef struct packed {
    kind_e      kind;
    logic [5:0] code;
  } fmt_t;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  function automatic fmt_t fmt_of(input logic [5:0] m);
    case (m)
      MN_ADD:   return '{K_R3, 6'h20};
      MN_ADDU:  return '{K_R3, 6'h21};
      MN_SUB:   return '{K_R3, 6'h22};
      MN_SUBU:  return '{K_R3, 6'h23};
      MN_AND:   return '{K_R3, 6'h24};
      MN_OR:    return '{K_R3, 6'h25};
      MN_XOR:   return '{K_R3, 6'h26};
      MN_NOR:   return '{K_R3, 6'h27};
      MN_SLT:   return '{K_R3, 6'h2a};
      MN_SLTU:  return '{K_R3, 6'h2b};
      MN_MULT:  return '{K_R2, 6'h18};
      MN_MULTU: return '{K_R2, 6'h19};
      MN_DIV:   return '{K_R2, 6'h1a};
      MN_DIVU:  return '{K_R2, 6'h1b};
      MN_MFLO:  return '{K_RD, 6'h12};
      MN_JR:    return '{K_RS, 6'h08};
      MN_ADDI:  return '{K_IS, 6'h08};
      MN_ADDIU: return '{K_IS, 6'h09};
      MN_SLTI:  return '{K_IS, 6'h0a};
      MN_SLTIU: return '{K_IS, 6'h0b};
      MN_BLT:   return '{K_IS, 6'h07};
      MN_BEQ:   return '{K_IS, 6'h04};
      MN_BNE:   return '{K_IS, 6'h05};
      MN_BLE:   return '{K_IS, 6'h06};
      MN_LW:    return '{K_IS, 6'h23};
      MN_LB:    return '{K_IS, 6'h20};
      MN_LBU:   return '{K_IS, 6'h24};
      MN_LH:    return '{K_IS, 6'h21};
      MN_LHU:   return '{K_IS, 6'h25};
      MN_SW:    return '{K_IS, 6'h2b};
      MN_SB:    return '{K_IS, 6'h28};
      MN_SH:    return '{K_IS, 6'h29};
      MN_ANDI:  return '{K_IU, 6'h0c};
      MN_ORI:   return '{K_IU, 6'h0d};
      MN_XORI:  return '{K_IU, 6'h0e};
      MN_J:     return '{K_J, 6'h02};
      MN_JAL:   return '{K_J, 6'h03};
      MN_PUSH:  return '{K_PUSH, 6'h00};
      MN_POP:   return '{K_POP, 6'h00};
      default:  return '{K_BAD, 6'h00};
    endcase
  endfunction
endpackage

// File: rtl/ins_field_pack.sv
// ins_field_pack: combinational mnemonic/fields/immediate -> encoded word(s) with range check
//   mnem, rs, rt, rd, imm : symbolic command
//   word0, word1          : first and (for PUSH/POP) second instruction word
//   is_pair               : command expands to two words
//   err                   : unknown mnemonic or immediate out of range (word0 = 0)
module ins_field_pack
  import ins_encoder_pkg::*;
#(
  parameter int SP_REG = 29
) (
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        is_pair,
  output logic        err
);
  fmt_t       f;
  logic [4:0] sp;
  logic       s16_ok, u16_ok, j_ok;
  assign f      = fmt_of(mnem);
  assign sp     = 5'(SP_REG);
  // signed 16-bit fit: bits 31..15 are a pure sign extension
  assign s16_ok = imm[31:15] == '0 || imm[31:15] == '1;
  assign u16_ok = imm[31:16] == '0;
  // jump target must be word aligned and inside the current 256 MB region
  assign j_ok   = imm[1:0] == '0 && imm[31:28] == '0;
  always_comb begin
    word0   = '0;
    word1   = '0;
    is_pair = 1'b0;
    err     = 1'b0;
    case (f.kind)
      K_R3: word0 = {6'h00, rs, rt, rd, 5'd0, f.code};
      K_R2: word0 = {6'h00, rs, rt, 10'd0, f.code};
      K_RD: word0 = {16'h0, rd, 5'd0, f.code};
      K_RS: word0 = {6'h00, rs, 15'd0, f.code};
      K_IS: begin
        err   = !s16_ok;
        word0 = s16_ok ? {f.code, rs, rt, imm[15:0]} : '0;
      end
      K_IU: begin
        err   = !u16_ok;
        word0 = u16_ok ? {f.code, rs, rt, imm[15:0]} : '0;
      end
      K_J: begin
        err   = !j_ok;
        word0 = j_ok ? {f.code, imm[27:2]} : '0;
      end
      K_PUSH: begin
        word0   = {OP_ADDIU, sp, sp, 16'hfffc};
        word1   = {OP_SW, sp, rt, 16'h0000};
        is_pair = 1'b1;
      end
      K_POP: begin
        word0   = {OP_LW, sp, rt, 16'h0000};
        word1   = {OP_ADDIU, sp, sp, 16'h0004};
        is_pair = 1'b1;
      end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/ins_encoder.sv
// ins_encoder: symbolic command stream -> 32-bit instruction word stream with PUSH/POP expansion
//   in_valid/in_ready, in_mnem, in_rs, in_rt, in_rd, in_imm : command input stream
//   out_valid/out_ready, ins_word, out_last, out_err        : instruction word output stream
//   err_count                                               : saturating errored-command count
module ins_encoder
  import ins_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int SP_REG    = 29
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_mnem,
  input  logic [4:0]           in_rs,
  input  logic [4:0]           in_rt,
  input  logic [4:0]           in_rd,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          ins_word,
  output logic                 out_last,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {S_IDLE, S_ONE, S_PAIR_A, S_PAIR_B} state_e;
  state_e      state, state_nx;
  logic [31:0] word0, word1, hold;
  logic        is_pair, err, accept;
  ins_field_pack #(.SP_REG(SP_REG)) u_pack (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .word0   (word0),
    .word1   (word1),
    .is_pair (is_pair),
    .err     (err)
  );
  assign out_valid = state != S_IDLE;
  // a new command may enter whenever the output register is empty or being drained by its last word
  assign in_ready  = rst_n && (state == S_IDLE || (state != S_PAIR_A && out_ready));
  assign accept    = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = accept ? (is_pair ? S_PAIR_A : S_ONE)
             : (state == S_PAIR_A && out_ready) ? S_PAIR_B
             : (out_valid && out_ready) ? S_IDLE
             : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ins_word  <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      hold      <= '0;
      err_count <= '0;
    end else if (accept) begin
      ins_word <= word0;
      out_last <= !is_pair;
      out_err  <= err;
      hold     <= word1;
      if (err && err_count != '1) err_count <= err_count + 1'b1;
    end else if (state == S_PAIR_A && out_ready) begin
      ins_word <= hold;
      out_last <= 1'b1;
      out_err  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ins_encoder.sv
// tb_ins_encoder: randomized scoreboard bench for ins_encoder against an arithmetic reference model
module tb_ins_encoder;
  import ins_encoder_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_err;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_imm, ins_word;
  logic [7:0]  err_count;
  typedef struct {
    logic [31:0] w;
    bit          last;
    bit          err;
    int          cnt;
  } exp_t;
  exp_t q[$];
  int   n_checks = 0, n_fail = 0, errs = 0, mode = 1;
  int   r3_fn[10] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  int   i_op[16]  = '{8, 9, 10, 11, 7, 4, 5, 6, 35, 32, 36, 33, 37, 43, 40, 41};
  bit          prev_stall = 0;
  logic [31:0] pw;
  logic        pl, pe;
  exp_t        ex;

  ins_encoder #(.ERR_CNT_W(8), .SP_REG(29)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .ins_word(ins_word), .out_last(out_last), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input int m, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] imm,
                                output logic [31:0] w0, output logic [31:0] w1,
                                output int n, output bit e);
    longint s, u;
    logic [31:0] f;
    s = longint'($signed(imm));
    u = longint'(imm);
    f = (32'(rs) << 21) | (32'(rt) << 16);
    w0 = 0; w1 = 0; n = 1; e = 0;
    if (m < 10) w0 = f | (32'(rd) << 11) | 32'(r3_fn[m]);
    else if (m < 14) w0 = f | 32'(24 + m - 10);
    else if (m == 14) w0 = (32'(rd) << 11) | 32'h12;
    else if (m == 15) w0 = (32'(rs) << 21) | 32'h08;
    else if (m < 32) begin
      e  = s < -32768 || s > 32767;
      w0 = e ? 0 : (32'(i_op[m-16]) << 26) | f | (imm & 32'hFFFF);
    end else if (m < 35) begin
      e  = u > 65535;
      w0 = e ? 0 : (32'(12 + m - 32) << 26) | f | imm;
    end else if (m < 37) begin
      e  = (imm % 4) != 0 || u >= 64'h1000_0000;
      w0 = e ? 0 : (32'(2 + m - 35) << 26) | (imm >> 2);
    end else if (m == 37) begin
      n  = 2;
      w0 = (32'd9 << 26) | (32'd29 << 21) | (32'd29 << 16) | 32'hFFFC;
      w1 = (32'd43 << 26) | (32'd29 << 21) | (32'(rt) << 16);
    end else if (m == 38) begin
      n  = 2;
      w0 = (32'd35 << 26) | (32'd29 << 21) | (32'(rt) << 16);
      w1 = (32'd9 << 26) | (32'd29 << 21) | (32'd29 << 16) | 32'd4;
    end else e = 1;
  endfunction

  function automatic void expect_cmd(input int m, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [31:0] imm);
    logic [31:0] w0, w1;
    int n;
    bit e;
    model(m, rs, rt, rd, imm, w0, w1, n, e);
    if (e) begin
      errs = errs < 255 ? errs + 1 : 255;
      q.push_back('{32'h0, 1'b1, 1'b1, errs});
    end else
      for (int i = 0; i < n; i++) q.push_back('{i == 0 ? w0 : w1, i == n - 1, 1'b0, errs});
  endfunction

  function automatic logic pick();
    return mode == 0 ? 1'($urandom) : mode == 1;
  endfunction

  function automatic logic [31:0] rimm();
    logic [31:0] b[8];
    int r;
    b = '{32'hFFFF8000, 32'h00007FFF, 32'h00008000, 32'hFFFF7FFF,
          32'h0000FFFF, 32'h00010000, 32'h0, 32'hFFFFFFFF};
    r = $urandom % 4;
    if (r == 0) return b[$urandom % 8];
    if (r == 1) return 32'($urandom_range(0, 65535)) - 32'd32768;
    if (r == 2) return $urandom & 32'h0FFFFFFC;
    return $urandom;
  endfunction

  task automatic send(input int m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm);
    bit acc = 0;
    int k = 0;
    in_valid = 1; in_mnem = 6'(m); in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    while (!acc && k < 200) begin
      out_ready = pick();
      @(negedge clk);
      acc = in_ready;
      if (acc) expect_cmd(m, rs, rt, rd, imm);
      @(posedge clk); #1;
      k++;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: mnem %0d never accepted", m);
    end
  endtask

  task automatic idle(input int c);
    in_valid = 0;
    repeat (c) begin
      out_ready = pick();
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    in_valid = 0;
    mode = 1;
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      out_ready = 1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // monitor: pops the scoreboard on every output transfer and checks stall stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall)
        chk("hold_stable", {29'd0, out_valid, out_last, out_err, ins_word}, {29'd0, 1'b1, pl, pe, pw});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got %0h with nothing outstanding", ins_word);
        end else begin
          ex = q.pop_front();
          chk("ins_word", 64'(ins_word), 64'(ex.w));
          chk("last_err_cnt", {54'd0, out_last, out_err, err_count}, {54'd0, ex.last, ex.err, 8'(ex.cnt)});
        end
      end
      prev_stall = out_valid && !out_ready;
      pw = ins_word; pl = out_last; pe = out_err;
    end else prev_stall = 0;
  end

  initial begin
    rst_n = 0; in_valid = 0; in_mnem = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {61'd0, out_valid, in_ready, out_last}, 64'd0);
    chk("reset_data", {23'd0, out_err, err_count, ins_word}, 64'd0);
    @(posedge clk); #1 rst_n = 1;
    mode = 1;
    send(MN_ADD, 1, 2, 3, 0);
    in_valid = 0;
    @(negedge clk);
    chk("add_latency", {31'd0, out_valid, ins_word}, {31'd0, 1'b1, 32'h00221820});
    @(posedge clk); #1;
    send(MN_ADDI, 0, 4, 0, 32'hFFFFFFFF);
    send(MN_ORI, 0, 4, 0, 32'h00010000);
    send(MN_J, 0, 0, 0, 32'h400);
    send(MN_J, 0, 0, 0, 32'h402);
    send(MN_PUSH, 0, 8, 0, 0);
    send(MN_POP, 0, 8, 0, 0);
    send(MN_ANDI, 3, 5, 0, 32'h0000FFFF);
    send(MN_SW, 29, 8, 0, 32'hFFFF8000);
    send(MN_BEQ, 1, 2, 0, 32'h00008000);
    drain();
    mode = 0;
    for (int i = 0; i < 400; i++) begin
      send($urandom_range(0, 44), 5'($urandom), 5'($urandom), 5'($urandom), rimm());
      if ($urandom % 4 == 0) idle($urandom_range(1, 3));
    end
    for (int i = 0; i < 100; i++) send(MN_ADD, 5'($urandom), 5'($urandom), 5'($urandom), 0);
    drain();
    for (int i = 0; i < 300; i++) send(50, 0, 0, 0, 0);
    drain();
    mode = 2;
    send(MN_PUSH, 0, 8, 0, 0);
    in_valid = 0;
    out_ready = 0;
    @(negedge clk);
    chk("pair_a_state", {61'd0, out_valid, out_last, in_ready}, {61'd0, 3'b100});
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_midpair", {54'd0, out_valid, in_ready, err_count}, 64'd0);
    q.delete();
    errs = 0;
    @(posedge clk); #1 rst_n = 1;
    mode = 1;
    repeat (6) begin
      out_ready = 1;
      @(negedge clk);
      chk("no_second_word", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    send(MN_POP, 0, 9, 0, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
